// File: rtl/canny_pkg.sv
`default_nettype none
// ============================================================================
// Module      : canny_pkg
// Description : Shared definitions for the Canny/NMS window front-end.
//               Holds the sequencer state encoding, default frame geometry,
//               and a helper that gives the number of full windows per frame.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package canny_pkg;

    localparam int DEF_WIDTH       = 636;
    localparam int DEF_DEPTH       = 508;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_CNT_W       = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Full (non-border) windows produced by one width x depth frame.
    function automatic int window_count(input int width, input int depth, input int k);
        return (width - k + 1) * (depth - k + 1);
    endfunction

endpackage : canny_pkg
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Raster-order column/row counter. Column wraps WIDTH-1 -> 0
//               and bumps the row; the row saturates at DEPTH-1.
// Ports       : clk, rst_n  - clock, async active-low reset
//               clr         - synchronous clear to (0,0), wins over inc
//               inc         - advance one pixel
//               row, col    - current pixel position (pre-increment)
//               last        - current position is the final pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
    import canny_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             last
);

    localparam logic [CNT_W-1:0] c_col_max = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_row_max = CNT_W'(DEPTH - 1);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == c_col_max) begin
                col_d = '0;
                // Saturate: the sequencer stops accepting after the last pixel,
                // so holding here keeps row inside the frame.
                if (row_q != c_row_max) begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == c_row_max) && (col_q == c_col_max);

endmodule : raster_counter
`default_nettype wire

// File: rtl/nms_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nms_window_ctrl
// Description : Frame sequencer for the 3x3 line-buffer/window stage ahead
//               of non-max suppression. Accepts a raster pixel stream, drives
//               the line-buffer shift enable, and presents a registered
//               window-valid with centre coordinates for full windows only.
// Ports       : clk, rst_n              - clock, async active-low reset
//               en_fun                  - function enable (low aborts)
//               frame_start             - arms a new frame (1-cycle pulse)
//               in_valid / in_ready     - upstream pixel handshake
//               shift_en                - line buffer / window shift strobe
//               buf_clr                 - line buffer clear on frame arm
//               out_valid / out_ready   - downstream window handshake
//               out_row, out_col        - centre of presented window
//               out_first, out_last     - first / last window of frame
//               busy                    - sequencer not idle
//               frame_done, frame_abort - end-of-frame status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module nms_window_ctrl
    import canny_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_fun,
    input  logic             frame_start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic             buf_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_row,
    output logic [CNT_W-1:0] out_col,
    output logic             out_first,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_abort
);

    localparam logic [CNT_W-1:0] c_k_m1 = CNT_W'(KERNEL_SIZE - 1);
    localparam logic [CNT_W-1:0] c_half = CNT_W'(KERNEL_SIZE / 2);

    state_e           state_q, state_d;
    logic             buf_clr_q, buf_clr_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_row_q, out_row_d;
    logic [CNT_W-1:0] out_col_q, out_col_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_abort_q, frame_abort_d;

    logic [CNT_W-1:0] w_row;
    logic [CNT_W-1:0] w_col;
    logic             w_last;
    logic             w_win_complete;
    logic             w_out_hs;

    // A new pixel may enter only when the window register is free or being
    // drained this cycle, so an unaccepted window is never overwritten.
    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign shift_en = in_ready && in_valid;
    assign w_out_hs = out_valid_q && out_ready;

    // Counters sit at (0,0) whenever no frame is streaming.
    raster_counter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_raster_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != RUN),
        .inc   (shift_en),
        .row   (w_row),
        .col   (w_col),
        .last  (w_last)
    );

    // Pixel (row,col) completes the window whose bottom-right corner it is.
    assign w_win_complete = shift_en && (w_row >= c_k_m1) && (w_col >= c_k_m1);

    always_comb begin
        state_d       = state_q;
        buf_clr_d     = 1'b0;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        out_valid_d   = out_valid_q;
        out_row_d     = out_row_q;
        out_col_d     = out_col_q;
        out_first_d   = out_first_q;
        out_last_d    = out_last_q;

        // A fresh window takes priority over draining the old one so that a
        // simultaneous handshake + completion keeps out_valid high.
        if (w_win_complete) begin
            out_valid_d = 1'b1;
            out_row_d   = w_row - c_half;
            out_col_d   = w_col - c_half;
            out_first_d = (w_row == c_k_m1) && (w_col == c_k_m1);
            out_last_d  = w_last;
        end else if (w_out_hs) begin
            out_valid_d = 1'b0;
        end

        if ((state_q != IDLE) && !en_fun) begin
            state_d       = IDLE;
            frame_abort_d = 1'b1;
            out_valid_d   = 1'b0;
            out_first_d   = 1'b0;
            out_last_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start && en_fun) begin
                        state_d   = ARM;
                        buf_clr_d = 1'b1;
                    end
                end
                ARM: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (shift_en && w_last) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (w_out_hs) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            buf_clr_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_row_q     <= '0;
            out_col_q     <= '0;
            out_first_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_clr_q     <= buf_clr_d;
            out_valid_q   <= out_valid_d;
            out_row_q     <= out_row_d;
            out_col_q     <= out_col_d;
            out_first_q   <= out_first_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign buf_clr     = buf_clr_q;
    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;
    assign out_first   = out_first_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

endmodule : nms_window_ctrl
`default_nettype wire

// File: tb/tb_nms_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nms_window_ctrl
// Description : Self-checking bench for nms_window_ctrl on an 8x6 frame with
//               a 3x3 kernel. A frame-level reference model predicts every
//               output each cycle; a handshake log is checked against the
//               expected raster order of window centres.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nms_window_ctrl;
    import canny_pkg::*;

    localparam int W    = 8;
    localparam int D    = 6;
    localparam int K    = 3;
    localparam int CW   = 10;
    localparam int NPIX = W * D;
    localparam int NWIN = (W - K + 1) * (D - K + 1);

    logic          clk, rst_n, en_fun, frame_start, in_valid, out_ready;
    logic          in_ready, shift_en, buf_clr, out_valid, out_first, out_last;
    logic          busy, frame_done, frame_abort;
    logic [CW-1:0] out_row, out_col;

    nms_window_ctrl #(
        .WIDTH       (W),
        .DEPTH       (D),
        .KERNEL_SIZE (K),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_fun      (en_fun),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .shift_en    (shift_en),
        .buf_clr     (buf_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_first   (out_first),
        .out_last    (out_last),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // mode: 0 idle, 1 arming, 2 streaming, 3 waiting for last window to drain
    typedef struct packed {
        logic [1:0]    mode;
        logic [7:0]    n;
        logic          valid;
        logic          first;
        logic          last;
        logic          clr;
        logic          done;
        logic          abort;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } model_t;

    function automatic model_t step(input model_t m, input logic en, input logic fs,
                                    input logic iv, input logic ordy);
        model_t nx;
        int     r, c;
        logic   xfer, hs;
        nx       = m;
        r        = int'(m.n) / W;
        c        = int'(m.n) % W;
        hs       = m.valid && ordy;
        xfer     = (m.mode == 2'd2) && (!m.valid || ordy) && iv;
        nx.clr   = 1'b0;
        nx.done  = 1'b0;
        nx.abort = 1'b0;
        if (m.mode != 2'd0 && !en) begin
            nx.mode  = 2'd0;
            nx.valid = 1'b0;
            nx.first = 1'b0;
            nx.last  = 1'b0;
            nx.abort = 1'b1;
        end else begin
            case (m.mode)
                2'd0: if (fs && en) begin nx.mode = 2'd1; nx.clr = 1'b1; end
                2'd1: begin nx.mode = 2'd2; nx.n = 8'd0; end
                2'd2: begin
                    if (hs) nx.valid = 1'b0;
                    if (xfer) begin
                        if (r >= K - 1 && c >= K - 1) begin
                            nx.valid = 1'b1;
                            nx.row   = CW'(r - K / 2);
                            nx.col   = CW'(c - K / 2);
                            nx.first = (r - K / 2 == K / 2) && (c - K / 2 == K / 2);
                            nx.last  = (r - K / 2 == D - 1 - K / 2) && (c - K / 2 == W - 1 - K / 2);
                        end
                        nx.n = m.n + 8'd1;
                        if (int'(m.n) + 1 == NPIX) nx.mode = 2'd3;
                    end
                end
                default: if (hs) begin nx.valid = 1'b0; nx.done = 1'b1; nx.mode = 2'd0; end
            endcase
        end
        return nx;
    endfunction

    model_t m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m, en_fun, frame_start, in_valid, out_ready);
    end

    logic exp_rdy;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_rdy = (m.mode == 2'd2) && (!m.valid || out_ready);
            chk("in_ready",    in_ready,    exp_rdy);
            chk("shift_en",    shift_en,    exp_rdy && in_valid);
            chk("buf_clr",     buf_clr,     m.clr);
            chk("out_valid",   out_valid,   m.valid);
            chk("busy",        busy,        m.mode != 2'd0);
            chk("frame_done",  frame_done,  m.done);
            chk("frame_abort", frame_abort, m.abort);
            if (m.valid) begin
                chk("out_row",   out_row,   m.row);
                chk("out_col",   out_col,   m.col);
                chk("out_first", out_first, m.first);
                chk("out_last",  out_last,  m.last);
            end
        end
    end

    // ---------------- handshake log ----------------
    logic [CW-1:0] hs_row[$];
    logic [CW-1:0] hs_col[$];
    logic          hs_first[$];
    logic          hs_last[$];

    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
            hs_row.push_back(out_row);
            hs_col.push_back(out_col);
            hs_first.push_back(out_first);
            hs_last.push_back(out_last);
        end
    end

    task automatic clear_log();
        hs_row.delete();
        hs_col.delete();
        hs_first.delete();
        hs_last.delete();
    endtask

    task automatic verify_frame(input string tag);
        chk($sformatf("%s window count", tag), hs_row.size(), NWIN);
        for (int k = 0; k < hs_row.size() && k < NWIN; k++) begin
            chk($sformatf("%s row[%0d]", tag, k), hs_row[k], 1 + k / (W - 2));
            chk($sformatf("%s col[%0d]", tag, k), hs_col[k], 1 + k % (W - 2));
            chk($sformatf("%s first[%0d]", tag, k), hs_first[k], k == 0);
            chk($sformatf("%s last[%0d]", tag, k), hs_last[k], k == NWIN - 1);
        end
        if (hs_row.size() == NWIN) begin
            chk($sformatf("%s first centre row", tag), hs_row[0], 1);
            chk($sformatf("%s first centre col", tag), hs_col[0], 1);
            chk($sformatf("%s last centre row", tag), hs_row[NWIN-1], 4);
            chk($sformatf("%s last centre col", tag), hs_col[NWIN-1], 6);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        en_fun      = 1'b1;
        frame_start = 1'b1;
        in_valid    = 1'b1;
        clear_log();
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input bit rnd_ready, input bit gaps);
        bit done;
        done = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (frame_done === 1'b1) done = 1'b1;
        end
        chk("frame_done seen", done, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic feed(input int n);
        int p;
        p = 0;
        for (int cyc = 0; cyc < 500 && p < n; cyc++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            if (shift_en === 1'b1) p++;
            @(posedge clk);
            #1;
        end
        chk("feed count", p, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pix;
        bit inc;
        rst_n = 1'b0; en_fun = 1'b0; frame_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("reset in_ready",  in_ready,  0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy",      busy,      0);
        chk("reset out_row",   out_row,   0);
        chk("reset out_col",   out_col,   0);
        chk("reset buf_clr",   buf_clr,   0);
        chk("window_count",    window_count(W, D, K), 24);
        rst_n = 1'b1;
        tick();

        // 1: full frame, no backpressure
        start_frame();
        run_frame(1'b0, 1'b0);
        verify_frame("t1");
        chk("t1 busy after done", busy, 0);

        // 2: random downstream backpressure
        start_frame();
        run_frame(1'b1, 1'b0);
        verify_frame("t2");

        // 3: arm cycle, input gaps, border suppression
        start_frame();
        chk("t3 arm buf_clr",  buf_clr,  1);
        chk("t3 arm in_ready", in_ready, 0);
        pix = 0;
        for (int cyc = 0; cyc < 400 && frame_done !== 1'b1; cyc++) begin
            in_valid  = (cyc % 3 != 1);
            out_ready = 1'b1;
            @(negedge clk);
            inc = (shift_en === 1'b1);
            if (inc) pix++;
            @(posedge clk);
            #1;
            if (inc && pix == 19) begin
                chk("t3 first window valid", out_valid, 1);
                chk("t3 first window row",   out_row,   1);
                chk("t3 first window col",   out_col,   1);
            end else if (pix < 19) begin
                chk("t3 border no valid", out_valid, 0);
            end
        end
        chk("t3 frame_done", frame_done, 1);
        in_valid = 1'b0;
        verify_frame("t3");
        tick();

        // 4: abort after 20 pixels, then a clean frame
        start_frame();
        feed(20);
        en_fun   = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("t4 abort pulse", frame_abort, 1);
        chk("t4 abort valid", out_valid,   0);
        chk("t4 abort busy",  busy,        0);
        tick();
        chk("t4 abort single", frame_abort, 0);
        start_frame();
        run_frame(1'b0, 1'b0);
        verify_frame("t4");

        // 6: pixels after frame end are held off; frame_start without en_fun ignored
        start_frame();
        run_frame(1'b0, 1'b0);
        verify_frame("t6a");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            tick();
            chk("t6 idle in_ready", in_ready, 0);
        end
        en_fun      = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t6 start w/o en busy",    busy,    0);
        chk("t6 start w/o en buf_clr", buf_clr, 0);
        start_frame();
        chk("t6 arm in_ready", in_ready, 0);
        run_frame(1'b0, 1'b0);
        verify_frame("t6b");

        // 5: frame_start mid-run ignored, then async reset mid-frame
        start_frame();
        feed(10);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t5 restart ignored buf_clr", buf_clr, 0);
        chk("t5 restart ignored busy",    busy,    1);
        feed(19);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 rst in_ready",  in_ready,  0);
        chk("t5 rst shift_en",  shift_en,  0);
        chk("t5 rst out_valid", out_valid, 0);
        chk("t5 rst out_row",   out_row,   0);
        chk("t5 rst out_col",   out_col,   0);
        chk("t5 rst first",     out_first, 0);
        chk("t5 rst last",      out_last,  0);
        chk("t5 rst busy",      busy,      0);
        chk("t5 rst abort",     frame_abort, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5 rst no done", frame_done, 0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_nms_window_ctrl
`default_nettype wire
